// File: rtl/memory_stage.sv
// Memory pipeline stage: data-memory loads/stores, stack push/pop, registered write-back,
// and the interrupt-entry / return-from-interrupt save/restore sequencer.
module memory_stage #(
  parameter int ADDR_W = 11,
  parameter logic [ADDR_W-1:0] SP_INIT = 11'h7FF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       alu_result,
  input  logic [15:0]       store_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        stack_op,
  input  logic              wb_in,
  input  logic [2:0]        rd_in,
  input  logic              interrupt,
  input  logic [15:0]       int_pc,
  input  logic [2:0]        flags_in,
  input  logic              rti,
  input  logic [15:0]       mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [15:0]       wb_data,
  output logic              wb_en,
  output logic [2:0]        rd_out,
  output logic [ADDR_W-1:0] sp,
  output logic              stall,
  output logic [1:0]        state_type,
  output logic [2:0]        save_state_counter,
  output logic [15:0]       restored_pc,
  output logic              pc_load
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SAVE = 2'd1,
    ST_RET  = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] SP_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] SP_TWO = {{(ADDR_W-2){1'b0}}, 2'b10};

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [15:0]       wb_data_q, wb_data_d;
  logic              wb_en_q, wb_en_d;
  logic [2:0]        rd_q, rd_d;
  logic [15:0]       rpc_q, rpc_d;
  logic              pc_load_q, pc_load_d;

  logic [ADDR_W-1:0] sp_p1_s, sp_p2_s, sp_m1_s, addr_s;
  logic [15:0]       wdata_s;
  logic              we_s, re_s, stall_s;

  assign sp_p1_s = sp_q + SP_ONE;
  assign sp_p2_s = sp_q + SP_TWO;
  assign sp_m1_s = sp_q - SP_ONE;

  // Next-state, memory-port and stall decode for idle ops and both sequences.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    sp_d      = sp_q;
    wb_data_d = wb_data_q;
    wb_en_d   = wb_en_q;
    rd_d      = rd_q;
    rpc_d     = rpc_q;
    pc_load_d = 1'b0;
    addr_s    = alu_result[ADDR_W-1:0];
    wdata_s   = store_data;
    we_s      = 1'b0;
    re_s      = 1'b0;
    stall_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A pending interrupt also stalls so the held op is not executed underneath it.
        stall_s = interrupt | rti | pending_q;
        if (interrupt || pending_q) begin
          state_d   = ST_SAVE;
          cnt_d     = 3'd1;
          pending_d = 1'b0;
          wb_en_d   = 1'b0;
        end else if (rti) begin
          state_d = ST_RET;
          cnt_d   = 3'd1;
          wb_en_d = 1'b0;
        end else begin
          rd_d    = rd_in;
          wb_en_d = wb_in;
          if (stack_op == 2'd1) begin
            addr_s    = sp_q;
            we_s      = 1'b1;
            sp_d      = sp_m1_s;
            wb_en_d   = 1'b0;
            wb_data_d = alu_result;
          end else if (stack_op == 2'd2) begin
            addr_s    = sp_p1_s;
            re_s      = 1'b1;
            sp_d      = sp_p1_s;
            wb_data_d = mem_rdata;
          end else if (mem_write) begin
            we_s      = 1'b1;
            wb_en_d   = 1'b0;
            wb_data_d = alu_result;
          end else if (mem_read) begin
            re_s      = 1'b1;
            wb_data_d = mem_rdata;
          end else begin
            wb_data_d = alu_result;
          end
        end
      end
      ST_SAVE: begin
        stall_s   = 1'b1;
        wb_en_d   = 1'b0;
        pending_d = pending_q | interrupt;
        case (cnt_q)
          3'd1: begin
            addr_s  = sp_q;
            wdata_s = int_pc;
            we_s    = 1'b1;
            sp_d    = sp_m1_s;
            cnt_d   = 3'd2;
          end
          3'd2: begin
            addr_s  = sp_q;
            wdata_s = {13'b0, flags_in};
            we_s    = 1'b1;
            sp_d    = sp_m1_s;
            cnt_d   = 3'd3;
          end
          default: begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
          end
        endcase
      end
      ST_RET: begin
        stall_s   = 1'b1;
        wb_en_d   = 1'b0;
        pending_d = pending_q | interrupt;
        case (cnt_q)
          3'd1: begin
            cnt_d = 3'd2;
          end
          3'd2: begin
            addr_s    = sp_p2_s;
            re_s      = 1'b1;
            rpc_d     = mem_rdata;
            pc_load_d = 1'b1;
            cnt_d     = 3'd3;
          end
          default: begin
            // Flags word is presented on mem_rdata here for the ALU stage.
            addr_s  = sp_p1_s;
            re_s    = 1'b1;
            sp_d    = sp_p2_s;
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
          end
        endcase
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // State, stack pointer and write-back registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 3'd0;
      pending_q <= 1'b0;
      sp_q      <= SP_INIT;
      wb_data_q <= 16'h0000;
      wb_en_q   <= 1'b0;
      rd_q      <= 3'd0;
      rpc_q     <= 16'h0000;
      pc_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      sp_q      <= sp_d;
      wb_data_q <= wb_data_d;
      wb_en_q   <= wb_en_d;
      rd_q      <= rd_d;
      rpc_q     <= rpc_d;
      pc_load_q <= pc_load_d;
    end
  end

  assign mem_addr           = addr_s;
  assign mem_wdata          = wdata_s;
  assign mem_we             = we_s & ~reset;
  assign mem_re             = re_s;
  assign stall              = stall_s;
  assign wb_data            = wb_data_q;
  assign wb_en              = wb_en_q;
  assign rd_out             = rd_q;
  assign sp                 = sp_q;
  assign state_type         = state_q;
  assign save_state_counter = cnt_q;
  assign restored_pc        = rpc_q;
  assign pc_load            = pc_load_q;

endmodule
